stream_demux: RTL
=================

Name: stream_demux

Overview:
- Parametrised, registered 1-to-NUM_OUT demultiplexer for valid/ready streams; the clocked next generation of the 4-way combinational demux.
- One input stream is routed to one selected output channel (unicast) or to all channels (broadcast).
- Each output channel has a one-entry holding register, so one stalled channel never corrupts another.
- Sits between a single producer and NUM_OUT independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_OUT, 4, number of output channels; legal range 2..16.
- SEL_W is a localparam, $clog2(NUM_OUT), and is not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers a beat.
- in_ready  output  1  block accepts the beat this cycle; combinational.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver the beat to every channel.
- out_valid  output  NUM_OUT  per-channel valid, one bit per channel.
- out_ready  input  NUM_OUT  per-channel consumer ready.
- out_data  output  NUM_OUT*DATA_W  packed; channel k occupies bits [k*DATA_W +: DATA_W].
- err_sel  output  1  one-cycle pulse: a beat with an out-of-range sel was dropped.
- drop_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the environment):
  - out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
  - Reset mid-transfer discards every held beat immediately.
- Per-channel slot FSM, two states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on pop when there is no simultaneous load.
  - FULL -> FULL on pop plus load in the same cycle (pass-through, no bubble).
- Pop on channel k: out_valid[k] & out_ready[k].
- drain_ok[k] = !out_valid[k] | out_ready[k].
- Accept = in_valid & in_ready. in_ready rules:
  - unicast, in_sel < NUM_OUT: in_ready = drain_ok[in_sel].
  - broadcast: in_ready = AND of drain_ok over all channels (all-or-nothing; no partial broadcast).
  - unicast, in_sel >= NUM_OUT (only possible when NUM_OUT is not a power of 2): in_ready = 1. The beat is dropped, err_sel pulses on the next cycle, and drop_cnt increments, saturating at 255.
- Latency: a beat accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: 1 beat/cycle per channel when its consumer keeps out_ready high.
- Data clearing: when a slot goes EMPTY without a reload, its out_data field is cleared to 0. Unselected and idle channels therefore always show 0.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] holds stable.
- Independence: out_ready of a non-targeted channel never affects in_ready in unicast mode.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready goes to in_ready.
- in_ready does not depend on in_valid.

Decomposition:
- Shared package stream_pkg:
  - DROP_CNT_W = 8.
  - slot state enum {SLOT_EMPTY, SLOT_FULL}.
  - helper function sel_in_range(sel, n).
- One sub-module, demux_slot: a single channel's holding register plus FSM.
  - Inputs: load, data, pop.
  - Outputs: valid, data.
  - Instantiated NUM_OUT times in a generate loop.
  - The top level holds the routing/ready logic and the drop counter.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=8'hA5, all out_ready=1 -> cycle+1: out_valid=4'b0100, channel 2 data=A5, other channels 0; in_ready stays 1.
- Channel 1 out_ready=0, send two beats to sel=1 (11, 22) -> first is held with out_valid[1]=1; in_ready=0 for sel=1 while a sel=3 beat (33) is accepted and delivered; after out_ready[1]=1, 11 then 22 emerge on consecutive cycles.
- in_bcast=1, data=5A, out_ready[0]=0 with channel 0 full -> in_ready=0, no channel loads; release out_ready[0] -> all four channels show 5A together one cycle after acceptance.
- NUM_OUT=3 build, in_sel=3, 300 beats -> in_ready=1 throughout, err_sel pulses per beat, drop_cnt saturates at 255, all out_valid=0.
- Continuous stream to sel=0 with out_ready[0]=1 -> one beat per cycle, no bubbles; deassert rst_n mid-stream -> out_valid and out_data go to 0 in the same cycle, asynchronously.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the registered stream demultiplexer.
// Slot state encoding, drop counter width and the select range test.
package stream_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic sel_in_range(
    input int unsigned sel,
    input int unsigned n
  );
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register with its own
// EMPTY/FULL state; data reads back as zero whenever the slot is empty.
module demux_slot
  import stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: a load wins over a pop, so pop+load passes straight through.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = load_data;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_d = load_data;
        end else if (pop) begin
          state_d = SLOT_EMPTY;
          data_d  = '0;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
        data_d  = '0;
      end
    endcase
  end

  // Slot registers; reset drops any held beat at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with broadcast.
// Out-of-range selects are accepted, dropped, flagged and counted.
module stream_demux
  import stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  localparam int SEL_W  = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      err_sel,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  logic [NUM_OUT-1:0]    drain_ok;
  logic [NUM_OUT-1:0]    sel_hit;
  logic [NUM_OUT-1:0]    load;
  logic [NUM_OUT-1:0]    pop;
  logic                  in_range;
  logic                  accept;
  logic                  drop;
  logic                  err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drain_ok = ~out_valid | out_ready;
  assign pop      = out_valid & out_ready;

  // Routing and ready: only the targeted slot(s) gate the producer.
  always_comb begin
    sel_hit  = '0;
    in_range = sel_in_range(32'(in_sel), NUM_OUT);
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_hit[k] = (32'(in_sel) == k);
    end
    if (in_bcast) begin
      in_ready = &drain_ok;
    end else if (in_range) begin
      in_ready = |(drain_ok & sel_hit);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    drop   = accept & ~in_bcast & ~in_range;
    load   = '0;
    if (accept) begin
      if (in_bcast) begin
        load = '1;
      end else if (in_range) begin
        load = sel_hit;
      end
    end
  end

  // Drop flag and saturating drop counter.
  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Error bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .load_data(in_data),
      .pop      (pop[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule
